// File: rtl/word_store_serializer.sv
// Stores a 16-bit word as two bytes on an 8-bit memory bus at base and base+1 under a ready handshake.
// Define WORD_STORE_LE_EN to emit the low byte first (little-endian); the default emits the high byte first.
module word_store_serializer #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       word,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_rdy,
  output logic [7:0]        data_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              wr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       word_q, word_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  function automatic logic [7:0] first_byte(input logic [15:0] w);
`ifdef WORD_STORE_LE_EN
    return w[7:0];
`else
    return w[15:8];
`endif
  endfunction

  function automatic logic [7:0] second_byte(input logic [15:0] w);
`ifdef WORD_STORE_LE_EN
    return w[15:8];
`else
    return w[7:0];
`endif
  endfunction

  // Outputs are computed for the state being entered, so every port comes straight from a flop.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    word_d  = word_q;
    base_d  = base_q;
    data_d  = data_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_HI;
          word_d  = word;
          base_d  = base_addr;
          data_d  = first_byte(word);
          addr_d  = base_addr;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          wr_d    = 1'b0;
          busy_d  = 1'b0;
        end
      end
      S_HI: begin
        if (mem_rdy) begin
          state_d = S_LO;
          data_d  = second_byte(word_q);
          addr_d  = base_q + ADDR_W'(1);
        end
      end
      S_LO: begin
        if (mem_rdy) begin
          state_d = S_DONE;
          wr_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        wr_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and overrides all inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      base_q  <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      base_q  <= base_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out = data_q;
  assign addr_out = addr_q;
  assign wr       = wr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
